// File: rtl/dense_layer_if.sv
// Control handshake and weight-ROM read port of dense_layer.
// The slave modport is the layer itself; master is the controller/ROM side.
interface dense_layer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 14
);
  logic                         start;
  logic                         busy;
  logic                         done;
  logic [ADDR_W-1:0]            w_addr;
  logic                         w_en;
  logic signed [DATA_WIDTH-1:0] w_data;

  modport master (
    output start,
    output w_data,
    input  busy,
    input  done,
    input  w_addr,
    input  w_en
  );

  modport slave (
    input  start,
    input  w_data,
    output busy,
    output done,
    output w_addr,
    output w_en
  );
endinterface

// File: rtl/dense_layer.sv
// Fully-connected layer: for each neuron it streams one weight row from a ROM with
// 1-cycle read latency, accumulates in_flat . w, adds the bias and saturates.
module dense_layer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 7,
  parameter int IN_DIM     = 1568,
  parameter int OUT_DIM    = 10,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  dense_layer_if.slave                 bus,
  input  logic signed [DATA_WIDTH-1:0] in_flat  [0:IN_DIM-1],
  input  logic signed [DATA_WIDTH-1:0] bias     [0:OUT_DIM-1],
  output logic signed [DATA_WIDTH-1:0] out_flat [0:OUT_DIM-1]
);
  localparam int ADDR_W = (OUT_DIM * IN_DIM > 1) ? $clog2(OUT_DIM * IN_DIM) : 1;
  localparam int I_W    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int O_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic [I_W-1:0] I_LAST = I_W'(IN_DIM - 1);
  localparam logic [I_W-1:0] I_PEN  = I_W'(IN_DIM - 2);
  localparam logic [O_W-1:0] O_LAST = O_W'(OUT_DIM - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRIME  = 3'd1;
  localparam logic [2:0] ST_MAC    = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  logic [2:0]                   state_r;
  logic [O_W-1:0]               o_r;
  logic [I_W-1:0]               i_r;
  logic signed [ACC_WIDTH-1:0]  acc_r;

  logic signed [DATA_WIDTH-1:0] act_s;
  logic signed [DATA_WIDTH-1:0] bias_s;
  logic signed [PROD_W-1:0]     act_ext_s;
  logic signed [PROD_W-1:0]     wgt_ext_s;
  logic signed [PROD_W-1:0]     prod_s;
  logic signed [ACC_WIDTH-1:0]  acc_next_s;
  logic signed [ACC_WIDTH-1:0]  shifted_s;
  logic signed [ACC_WIDTH-1:0]  sum_s;
  logic signed [DATA_WIDTH-1:0] sat_s;

  // MAC datapath and the floor-shift / bias / saturate result for the current neuron
  always_comb begin
    act_s      = in_flat[i_r];
    bias_s     = bias[o_r];
    act_ext_s  = {{DATA_WIDTH{act_s[DATA_WIDTH-1]}}, act_s};
    wgt_ext_s  = {{DATA_WIDTH{bus.w_data[DATA_WIDTH-1]}}, bus.w_data};
    prod_s     = act_ext_s * wgt_ext_s;
    acc_next_s = acc_r + {{(ACC_WIDTH-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    shifted_s  = acc_r >>> FRAC_BITS;
    sum_s      = shifted_s + {{(ACC_WIDTH-DATA_WIDTH){bias_s[DATA_WIDTH-1]}}, bias_s};
    if (sum_s > SAT_MAX) begin
      sat_s = SAT_MAX[DATA_WIDTH-1:0];
    end else if (sum_s < SAT_MIN) begin
      sat_s = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_s = sum_s[DATA_WIDTH-1:0];
    end
  end

  // Sequencer: the ROM address is registered one cycle ahead so that w_data lines up
  // with i_r. Incrementing past the last word of a row leaves w_addr on the next row's base.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      o_r        <= '0;
      i_r        <= '0;
      acc_r      <= '0;
      bus.w_addr <= '0;
      bus.w_en   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            o_r        <= '0;
            bus.busy   <= 1'b1;
            bus.w_addr <= '0;
            bus.w_en   <= 1'b1;
            state_r    <= ST_PRIME;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_PRIME: begin
          acc_r      <= '0;
          i_r        <= '0;
          bus.w_addr <= bus.w_addr + ADDR_W'(1'b1);
          bus.w_en   <= (I_LAST != '0);
          state_r    <= ST_MAC;
        end
        ST_MAC: begin
          acc_r <= acc_next_s;
          if (i_r == I_LAST) begin
            bus.w_en <= 1'b0;
            state_r  <= ST_WRITE;
          end else begin
            i_r        <= i_r + I_W'(1'b1);
            bus.w_addr <= bus.w_addr + ADDR_W'(1'b1);
            bus.w_en   <= (i_r != I_PEN);
            state_r    <= ST_MAC;
          end
        end
        ST_WRITE: begin
          if (o_r == O_LAST) begin
            state_r  <= ST_FINISH;
          end else begin
            o_r      <= o_r + O_W'(1'b1);
            bus.w_en <= 1'b1;
            state_r  <= ST_PRIME;
          end
        end
        ST_FINISH: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          bus.w_en <= 1'b0;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  // Result registers: each entry changes only in its own WRITE cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < OUT_DIM; n++) begin
        out_flat[n] <= '0;
      end
    end else if (state_r == ST_WRITE) begin
      out_flat[o_r] <= sat_s;
    end else begin
      out_flat[o_r] <= out_flat[o_r];
    end
  end
endmodule
